bus_rr_scheduler: RTL and testbench

//  Round-robin bus scheduler that shares one system bus between N_MASTERS requesters.

---
 rtl/bus_rr_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_bus_rr_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_scheduler.sv
// -----------------------------------------------------------------------------
// bus_rr_scheduler
//
// Purpose
//   Shares one system bus between N_MASTERS requesters using round-robin
//   priority. The registered one-hot grant and its index drive the bus mux
//   select directly. A hold limit stops a single owner from starving the
//   others while they are waiting. One dead cycle (all grants low) always
//   separates two ownerships, even when the same master wins again.
//
// Handshake
//   request[i] is a level "valid": master i holds it high for as long as it
//   wants the bus. grant[i] is the matching "ready": the master owns the bus
//   during every cycle that grant[i] is high. The master ends its ownership
//   by dropping request[i]. The scheduler may also revoke a grant at the hold
//   limit, and it signals that with a one-cycle preempt pulse. Requests are
//   not latched: a request that drops before it is granted is forgotten.
//
// Parameters
//   N_MASTERS  number of requesters, 2..16
//   MAX_HOLD   maximum grant cycles while another master is requesting, >= 2
//   IDW        index width, $clog2(N_MASTERS)
//   CNT_W      hold counter width, $clog2(MAX_HOLD)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   request     in   [N_MASTERS-1:0] per-master bus request (level)
//   grant       out  [N_MASTERS-1:0] registered grant, one-hot or zero
//   grant_id    out  [IDW-1:0] index of the owner; keeps its last value while idle
//   busy        out  high while any grant is high (mirrors the FSM OWN state)
//   preempt     out  one-cycle pulse after a grant is revoked at the hold limit
//
// Optional build macro
//   SCHED_DEBUG_EN  when defined, adds D_PRIORITY (= round-robin pointer) and
//                   D_HOLD (= hold counter). Scheduling is identical either way.
// -----------------------------------------------------------------------------
module bus_rr_scheduler #(
  parameter  int N_MASTERS = 4,
  parameter  int MAX_HOLD  = 16,
  localparam int IDW       = $clog2(N_MASTERS),
  localparam int CNT_W     = $clog2(MAX_HOLD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] request,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 preempt
`ifdef SCHED_DEBUG_EN
  ,
  output logic [IDW-1:0]       D_PRIORITY,
  output logic [CNT_W-1:0]     D_HOLD
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [IDW-1:0]   ID_LAST   = IDW'(N_MASTERS - 1);
  localparam logic [IDW:0]     N_CMP     = (IDW + 1)'(N_MASTERS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t                 state_q,    state_d;
  logic [N_MASTERS-1:0]   grant_q,    grant_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic                   preempt_q,  preempt_d;
  logic [IDW-1:0]         ptr_q,      ptr_d;
  logic [CNT_W-1:0]       hold_q,     hold_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick
  // The request vector is rotated so that position 0 is the master at ptr.
  // The first set bit of the rotated vector is the offset of the winner from
  // ptr. That offset is then mapped back to a master index modulo N_MASTERS.
  // ---------------------------------------------------------------------------
  logic [2*N_MASTERS-1:0] req_dbl;
  logic [N_MASTERS-1:0]   req_rot;
  logic                   pick_vld;
  logic [IDW-1:0]         pick_off;
  logic [IDW:0]           pick_sum;
  logic [IDW-1:0]         pick_idx;

  assign req_dbl = {request, request};
  assign req_rot = N_MASTERS'(req_dbl >> ptr_q);

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    // Scan from the highest offset down so that the lowest set offset is the
    // last one written and therefore wins.
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_off = IDW'(k);
      end
    end
  end

  assign pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= N_CMP) ? IDW'(pick_sum - N_CMP) : IDW'(pick_sum);

  // ---------------------------------------------------------------------------
  // Owner status
  // ---------------------------------------------------------------------------
  logic           owner_req;
  logic           others_req;
  logic [IDW-1:0] ptr_after_owner;

  assign owner_req       = request[grant_id_q];
  // grant_q holds exactly the owner's bit in OWN, so masking it out leaves
  // the competing requests.
  assign others_req      = |(request & ~grant_q);
  assign ptr_after_owner = (grant_id_q == ID_LAST) ? '0 : grant_id_q + IDW'(1);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    preempt_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_d     = hold_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          grant_id_d        = pick_idx;
          hold_d            = '0;
          state_d           = S_OWN;
        end
      end

      S_OWN: begin
        if (!owner_req) begin
          // Release is checked first. When it happens on the same edge as a
          // hold-limit revoke, no preempt pulse is raised.
          grant_d = '0;
          ptr_d   = ptr_after_owner;
          hold_d  = '0;
          state_d = S_IDLE;
        end else if ((hold_q == HOLD_LAST) && others_req) begin
          // The owner still wants the bus, so it ranks last in the next round.
          grant_d   = '0;
          preempt_d = 1'b1;
          ptr_d     = ptr_after_owner;
          hold_d    = '0;
          state_d   = S_IDLE;
        end else if (hold_q != HOLD_LAST) begin
          // The counter saturates. An uncontended owner stays at the limit
          // and is revoked on the first edge that sees contention.
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      preempt_q  <= 1'b0;
      ptr_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      preempt_q  <= preempt_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == S_OWN);
  assign preempt  = preempt_q;

`ifdef SCHED_DEBUG_EN
  assign D_PRIORITY = ptr_q;
  assign D_HOLD     = hold_q;
`endif

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_scheduler
//
// Self-checking bench for bus_rr_scheduler with N_MASTERS=4 and MAX_HOLD=4.
// A reference model at the rising edge pushes the expected
// {grant, grant_id, busy, preempt} of every cycle into exp_q. A monitor on the
// falling edge pops each entry and compares it with the DUT outputs. Directed
// tables check the documented scenarios. A long randomized run with occasional
// asynchronous resets follows.
// -----------------------------------------------------------------------------
module tb_bus_rr_scheduler;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;
  localparam int W        = N + IDW + 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           preempt;
`ifdef SCHED_DEBUG_EN
  logic [IDW-1:0] d_prio;
  logic [1:0]     d_hold;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  bus_rr_scheduler #(
    .N_MASTERS (N),
    .MAX_HOLD  (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .request  (request),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
`ifdef SCHED_DEBUG_EN
    .D_PRIORITY (d_prio),
    .D_HOLD     (d_hold),
`endif
    .preempt  (preempt)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. It tracks the owner as an integer (-1 = none), counts
  // the cycles that owner has held the bus, and keeps the round-robin
  // start point.
  // ---------------------------------------------------------------------------
  int m_owner   = -1;
  int m_cycles  = 0;
  int m_ptr     = 0;
  int m_last    = 0;
  bit m_preempt = 1'b0;

  task automatic model_step(input logic r_rst, input logic [N-1:0] r);
    logic [N-1:0] g;
    if (r_rst) begin
      m_owner   = -1;
      m_cycles  = 0;
      m_ptr     = 0;
      m_last    = 0;
      m_preempt = 1'b0;
    end else begin
      m_preempt = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_ptr + k) % N]) begin
            m_owner  = (m_ptr + k) % N;
            m_last   = m_owner;
            m_cycles = 1;
            break;
          end
        end
      end else if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if ((m_cycles >= MAX_HOLD) && ((r & ~(N'(1) << m_owner)) != '0)) begin
        m_preempt = 1'b1;
        m_ptr     = (m_owner + 1) % N;
        m_owner   = -1;
      end else begin
        m_cycles++;
      end
    end
    g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    exp_q.push_back({g, IDW'(m_last), (m_owner >= 0), m_preempt});
  endtask

  initial begin : ref_model
    forever begin
      @(posedge clk);
      model_step(rst, request);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_grant",    32'(grant),    32'(e[W-1 -: N]));
        check("sb_grant_id", 32'(grant_id), 32'(e[3:2]));
        check("sb_busy",     32'(busy),     32'(e[1]));
        check("sb_preempt",  32'(preempt),  32'(e[0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present r for one rising edge, then return just after that edge.
  task automatic step(input logic [N-1:0] r);
    request = r;
    @(posedge clk);
    #1;
  endtask

  // Step, then check grant and preempt against constants.
  task automatic run_row(input string tag, input logic [N-1:0] r,
                         input logic [N-1:0] g, input logic p);
    step(r);
    check({tag, "_grant"},   32'(grant),   32'(g));
    check({tag, "_preempt"}, 32'(preempt), 32'(p));
  endtask

  // Assert rst away from any clock edge, check that the outputs clear at
  // once, keep rst high across one rising edge, then release it.
  task automatic pulse_reset(input logic [N-1:0] r_during);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_grant",    32'(grant),    32'(0));
    check("arst_busy",     32'(busy),     32'(0));
    check("arst_preempt",  32'(preempt),  32'(0));
    check("arst_grant_id", 32'(grant_id), 32'(0));
    request = r_during;
    @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    logic [N-1:0] rnd;
    rst     = 1'b1;
    request = '0;
    rnd     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant",    32'(grant),    32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_preempt",  32'(preempt),  32'(0));
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Single master for 3 cycles, then a ptr=1 probe.
    run_row("t1", 4'b0001, 4'b0001, 1'b0);
    check("t1_busy",     32'(busy),     32'(1));
    check("t1_grant_id", 32'(grant_id), 32'(0));
    run_row("t1", 4'b0001, 4'b0001, 1'b0);
    run_row("t1", 4'b0001, 4'b0001, 1'b0);
    run_row("t1", 4'b0000, 4'b0000, 1'b0);
    check("t1_idle_busy", 32'(busy), 32'(0));
    run_row("t1", 4'b0000, 4'b0000, 1'b0);
    run_row("t1_ptr1", 4'b1011, 4'b0010, 1'b0);
    run_row("t1", 4'b0000, 4'b0000, 1'b0);

    pulse_reset(4'b0000);

    // All request, each drops 2 cycles after its grant.
    run_row("t2", 4'b1111, 4'b0001, 1'b0);
    run_row("t2", 4'b1111, 4'b0001, 1'b0);
    run_row("t2", 4'b1110, 4'b0000, 1'b0);
    run_row("t2", 4'b1110, 4'b0010, 1'b0);
    run_row("t2", 4'b1110, 4'b0010, 1'b0);
    run_row("t2", 4'b1100, 4'b0000, 1'b0);
    run_row("t2", 4'b1100, 4'b0100, 1'b0);
    run_row("t2", 4'b1100, 4'b0100, 1'b0);
    run_row("t2", 4'b1000, 4'b0000, 1'b0);
    run_row("t2", 4'b1000, 4'b1000, 1'b0);
    run_row("t2", 4'b1000, 4'b1000, 1'b0);
    run_row("t2", 4'b0000, 4'b0000, 1'b0);

    // Hold-limit preempt of master 0 by master 2.
    run_row("t3", 4'b0001, 4'b0001, 1'b0);
    run_row("t3", 4'b0101, 4'b0001, 1'b0);
    run_row("t3", 4'b0101, 4'b0001, 1'b0);
    run_row("t3", 4'b0101, 4'b0001, 1'b0);
    run_row("t3", 4'b0101, 4'b0000, 1'b1);
    run_row("t3", 4'b0101, 4'b0100, 1'b0);
    run_row("t3", 4'b0000, 4'b0000, 1'b0);
    run_row("t3", 4'b0000, 4'b0000, 1'b0);

    // ptr=3: master 3 first, then wrap to master 0.
    run_row("t4", 4'b1001, 4'b1000, 1'b0);
    run_row("t4", 4'b1001, 4'b1000, 1'b0);
    run_row("t4", 4'b0001, 4'b0000, 1'b0);
    run_row("t4", 4'b0001, 4'b0001, 1'b0);
    run_row("t4", 4'b0000, 4'b0000, 1'b0);

    // Release and preempt conditions on the same edge.
    run_row("t5", 4'b0010, 4'b0010, 1'b0);
    run_row("t5", 4'b0011, 4'b0010, 1'b0);
    run_row("t5", 4'b0011, 4'b0010, 1'b0);
    run_row("t5", 4'b0011, 4'b0010, 1'b0);
    run_row("t5", 4'b0001, 4'b0000, 1'b0);
    run_row("t5", 4'b0001, 4'b0001, 1'b0);
    run_row("t5", 4'b0000, 4'b0000, 1'b0);

    // Uncontended long hold, then contention after saturation.
    for (int i = 0; i < 8; i++) run_row("t6", 4'b0010, 4'b0010, 1'b0);
    run_row("t6", 4'b0110, 4'b0000, 1'b1);
    run_row("t6", 4'b0110, 4'b0100, 1'b0);
    run_row("t6", 4'b0000, 4'b0000, 1'b0);

    // Same master re-requests: a dead cycle still separates the grants.
    run_row("t7", 4'b1000, 4'b1000, 1'b0);
    run_row("t7", 4'b0000, 4'b0000, 1'b0);
    run_row("t7", 4'b1000, 4'b1000, 1'b0);
    run_row("t7", 4'b0000, 4'b0000, 1'b0);

    // Reset during OWN; arbitration restarts at master 0.
    run_row("t8", 4'b0010, 4'b0010, 1'b0);
    pulse_reset(4'b0110);
    run_row("t8_after_rst", 4'b0110, 4'b0010, 1'b0);
    check("t8_grant_id", 32'(grant_id), 32'(1));
    run_row("t8", 4'b0000, 4'b0000, 1'b0);

    // Randomized traffic: requests toggle occasionally so that owners keep the
    // bus for a while and contention builds up.
    for (int c = 0; c < 3000; c++) begin
      if ((c % 750) == 749) begin
        pulse_reset(4'($urandom));
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) rnd[i] = ~rnd[i];
      end
      step(rnd);
    end

    repeat (3) step(4'b0000);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
